fetch_queue: RTL and testbench

Instruction fetch front end that sits directly upstream of the IF/ID pipeline register of the 5-stage MIPS core.
- Generates word-aligned fetch addresses and issues them to the byte-addressed instruction memory port, which has variable response latency.
- Buffers returned words, with their PC and PC+4, in a small FIFO, and presents one instruction per cycle to ID.
- Honours ID stall (WPCIR) and branch/jump redirect, including discard of stale in-flight responses.

---
 rtl/fetch_queue_pkg.sv | 14 +
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_queue_chk.sv | 34 +++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/fetch_queue.sv | 141 ++++++++++++++
 tb/tb_fetch_queue.sv | 220 ++++++++++++++++++++++
 6 files changed

// File: rtl/fetch_queue_pkg.sv
// Core-wide fetch constants shared with the pipeline top: NOP encoding, flushed-slot PC marker,
// default reset PC and word alignment.
package fetch_queue_pkg;

    localparam logic [31:0] CPU_NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] CPU_FLUSH_PC  = 32'hFFFF_FFFF;
    localparam logic [31:0] CPU_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] CPU_WORD_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & CPU_WORD_MASK;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: instruction memory request/response port plus the IF/ID-facing side.
interface fetch_queue_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        if_valid;
    logic [31:0] if_ir;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        id_stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output mem_req, mem_addr, if_valid, if_ir, if_pc, if_pc4,
        input  mem_gnt, mem_rvalid, mem_rdata, id_stall, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, if_valid, if_ir, if_pc, if_pc4,
        output mem_gnt, mem_rvalid, mem_rdata, id_stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_queue_chk.sv
// Protocol and occupancy checks for fetch_queue.
module fetch_queue_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clock,
    input logic          reset,
    input logic          mem_rvalid,
    input logic          issue,
    input logic          accept,
    input logic          data_push,
    input logic          data_pop,
    input logic          data_full,
    input logic          pc_full,
    input logic          pc_empty,
    input logic [CW-1:0] count,
    input logic [CW-1:0] inflight,
    input logic [CW-1:0] pc_count
);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    a_rvalid_needs_inflight: assert property (@(posedge clock) disable iff (reset)
        mem_rvalid |-> (inflight != {CW{1'b0}}));
    a_credit_bound: assert property (@(posedge clock) disable iff (reset)
        ({1'b0, count} + {1'b0, inflight}) <= DEPTH_C);
    a_pc_tracks_inflight: assert property (@(posedge clock) disable iff (reset)
        pc_count == inflight);
    a_no_data_overflow: assert property (@(posedge clock) disable iff (reset)
        !(data_push && data_full && !data_pop));
    a_no_pc_overflow: assert property (@(posedge clock) disable iff (reset)
        !(issue && pc_full));
    a_accept_has_pc: assert property (@(posedge clock) disable iff (reset)
        accept |-> !pc_empty);
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_N = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == {CW{1'b0}});
    assign full      = (count_r == DEPTH_N);
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage, pointers and occupancy; clear wins over push/pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited request issue, in-order response buffering with
// PC tagging, and redirect flush that discards responses already in flight.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = CPU_RESET_PC,
    parameter logic [31:0] NOP_WORD = CPU_NOP_WORD
) (
    input logic          clock,
    input logic          reset,
    fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_N = CW'(DEPTH);

    logic [31:0]   fetch_pc_r, fetch_pc_n;
    logic [CW-1:0] inflight_r, inflight_n;
    logic [CW-1:0] discard_r, discard_n;
    logic [CW-1:0] count_s, pc_count_s, stale_s;
    logic [CW:0]   credit_sum_s;
    logic          req_s, issue_s, accept_s, drop_s, push_s, pop_s;
    logic          data_empty_s, data_full_s, pc_empty_s, pc_full_s;
    logic [31:0]   pc_head_s;
    logic [95:0]   data_head_s;

    assign credit_sum_s = {1'b0, count_s} + {1'b0, inflight_r};
    assign req_s    = !reset && !bus.redirect && (credit_sum_s < DEPTH_C);
    assign issue_s  = req_s && bus.mem_gnt;
    // Responses with nothing outstanding are protocol errors and are ignored.
    assign accept_s = bus.mem_rvalid && (inflight_r != {CW{1'b0}});
    assign drop_s   = accept_s && (discard_r != {CW{1'b0}});
    assign push_s   = accept_s && !drop_s && !bus.redirect;
    assign pop_s    = !data_empty_s && !bus.id_stall && !bus.redirect;
    assign stale_s  = inflight_r - CW'(accept_s);

    assign bus.mem_req  = req_s;
    assign bus.mem_addr = fetch_pc_r;

    sync_fifo #(.WIDTH(96), .DEPTH(DEPTH)) u_data_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .clear (bus.redirect),
        .wdata ({bus.mem_rdata, pc_head_s, pc_head_s + 32'd4}),
        .rdata (data_head_s),
        .full  (data_full_s),
        .empty (data_empty_s),
        .count (count_s)
    );

    // Issued addresses retire on every accepted response, discarded or not, so it is never cleared.
    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_fifo (
        .clock (clock),
        .reset (reset),
        .push  (issue_s),
        .pop   (accept_s),
        .clear (1'b0),
        .wdata (fetch_pc_r),
        .rdata (pc_head_s),
        .full  (pc_full_s),
        .empty (pc_empty_s),
        .count (pc_count_s)
    );

    // Next-state for fetch PC and the outstanding/discard counters.
    always_comb begin
        fetch_pc_n = fetch_pc_r;
        discard_n  = discard_r;
        inflight_n = inflight_r;
        case ({issue_s, accept_s})
            2'b10:   inflight_n = inflight_r + CW'(1'b1);
            2'b01:   inflight_n = inflight_r - CW'(1'b1);
            default: inflight_n = inflight_r;
        endcase
        if (bus.redirect) begin
            fetch_pc_n = word_align(bus.redirect_pc);
            if (stale_s > DEPTH_N) begin
                discard_n = DEPTH_N;
            end else begin
                discard_n = stale_s;
            end
        end else begin
            if (issue_s) begin
                fetch_pc_n = fetch_pc_r + 32'd4;
            end else begin
                fetch_pc_n = fetch_pc_r;
            end
            if (drop_s) begin
                discard_n = discard_r - CW'(1'b1);
            end else begin
                discard_n = discard_r;
            end
        end
    end

    // Fetch PC and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            inflight_r <= {CW{1'b0}};
            discard_r  <= {CW{1'b0}};
        end else begin
            fetch_pc_r <= fetch_pc_n;
            inflight_r <= inflight_n;
            discard_r  <= discard_n;
        end
    end

    // Head presentation with the flushed-slot markers when empty.
    always_comb begin
        bus.if_valid = !data_empty_s;
        if (!data_empty_s) begin
            bus.if_ir  = data_head_s[95:64];
            bus.if_pc  = data_head_s[63:32];
            bus.if_pc4 = data_head_s[31:0];
        end else begin
            bus.if_ir  = NOP_WORD;
            bus.if_pc  = CPU_FLUSH_PC;
            bus.if_pc4 = 32'h0000_0000;
        end
    end

    fetch_queue_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clock      (clock),
        .reset      (reset),
        .mem_rvalid (bus.mem_rvalid),
        .issue      (issue_s),
        .accept     (accept_s),
        .data_push  (push_s),
        .data_pop   (pop_s),
        .data_full  (data_full_s),
        .pc_full    (pc_full_s),
        .pc_empty   (pc_empty_s),
        .count      (count_s),
        .inflight   (inflight_r),
        .pc_count   (pc_count_s)
    );
endmodule

// File: tb/tb_fetch_queue.sv
// Directed vector bench for fetch_queue with a fixed-latency in-order memory returning addr+1.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    typedef struct {
        bit          rst;
        int          lat;
        bit          gnt;
        bit          stall;
        bit          redir;
        logic [31:0] rpc;
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic  clock;
    logic  reset;
    vec_t  vecs[$];
    pend_t pend_q[$];
    int    cyc;
    int    lat_r;
    int    n_vec;
    int    n_err;

    fetch_queue_if bus();

    fetch_queue #(.DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic void add(bit rst, int lat, bit gnt, bit stall, bit redir, logic [31:0] rpc,
                                bit req, logic [31:0] addr, bit valid, logic [31:0] pc);
        vecs.push_back('{rst, lat, gnt, stall, redir, rpc, req, addr, valid, pc});
    endfunction

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    task automatic chk_idle(input int idx);
        chk(idx, "if_valid", {31'd0, bus.if_valid}, 32'd0);
        chk(idx, "if_ir", bus.if_ir, CPU_NOP_WORD);
        chk(idx, "if_pc", bus.if_pc, CPU_FLUSH_PC);
        chk(idx, "if_pc4", bus.if_pc4, 32'd0);
    endtask

    // One clock: record an issue, advance, then present any due response for the new cycle.
    task automatic tick();
        logic        iss;
        logic [31:0] a;
        iss = bus.mem_req && bus.mem_gnt && !reset;
        a   = bus.mem_addr;
        @(posedge clock);
        #1;
        cyc++;
        if (iss) pend_q.push_back('{a, cyc - 1 + lat_r});
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = pend_q[0].addr + 32'd1;
            void'(pend_q.pop_front());
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'd0;
        end
    endtask

    task automatic do_reset(input int lat);
        reset           = 1'b1;
        bus.mem_gnt     = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = 32'd0;
        bus.id_stall    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        pend_q.delete();
        lat_r = lat;
        @(posedge clock);
        #1;
        n_vec++;
        chk(-1, "reset mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk_idle(-1);
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        vec_t v;
        clock = 1'b0;
        reset = 1'b1;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        lat_r = 1;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
        bus.id_stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'd0;

        // Streaming, latency 1.
        add(1, 1, 1, 0, 0, 32'h0, 1, 32'h00, 0, 32'h0);
        add(0, 1, 1, 0, 0, 32'h0, 1, 32'h04, 0, 32'h0);
        add(0, 1, 1, 0, 0, 32'h0, 1, 32'h08, 1, 32'h0);
        add(0, 1, 1, 0, 0, 32'h0, 1, 32'h0C, 1, 32'h4);
        add(0, 1, 1, 0, 0, 32'h0, 1, 32'h10, 1, 32'h8);
        add(0, 1, 1, 0, 0, 32'h0, 1, 32'h14, 1, 32'hC);
        // No grant for 10 cycles.
        add(1, 1, 0, 0, 0, 32'h0, 1, 32'h00, 0, 32'h0);
        for (int i = 0; i < 9; i++) add(0, 1, 0, 0, 0, 32'h0, 1, 32'h00, 0, 32'h0);
        // ID stall fills credit, then release.
        add(1, 1, 1, 1, 0, 32'h0, 1, 32'h00, 0, 32'h0);
        add(0, 1, 1, 1, 0, 32'h0, 1, 32'h04, 0, 32'h0);
        add(0, 1, 1, 1, 0, 32'h0, 1, 32'h08, 1, 32'h0);
        add(0, 1, 1, 1, 0, 32'h0, 1, 32'h0C, 1, 32'h0);
        add(0, 1, 1, 1, 0, 32'h0, 0, 32'h10, 1, 32'h0);
        add(0, 1, 1, 1, 0, 32'h0, 0, 32'h10, 1, 32'h0);
        add(0, 1, 1, 0, 0, 32'h0, 0, 32'h10, 1, 32'h0);
        add(0, 1, 1, 0, 0, 32'h0, 1, 32'h10, 1, 32'h4);
        add(0, 1, 1, 0, 0, 32'h0, 1, 32'h14, 1, 32'h8);
        add(0, 1, 1, 0, 0, 32'h0, 1, 32'h18, 1, 32'hC);
        add(0, 1, 1, 0, 0, 32'h0, 1, 32'h1C, 1, 32'h10);
        // Latency 3, redirect to 0x103 with two requests in flight.
        add(1, 3, 1, 0, 0, 32'h0,   1, 32'h000, 0, 32'h0);
        add(0, 3, 1, 0, 0, 32'h0,   1, 32'h004, 0, 32'h0);
        add(0, 3, 1, 0, 1, 32'h103, 0, 32'h008, 0, 32'h0);
        add(0, 3, 1, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0);
        add(0, 3, 1, 0, 0, 32'h0,   1, 32'h104, 0, 32'h0);
        add(0, 3, 1, 0, 0, 32'h0,   1, 32'h108, 0, 32'h0);
        add(0, 3, 1, 0, 0, 32'h0,   1, 32'h10C, 0, 32'h0);
        add(0, 3, 1, 0, 0, 32'h0,   0, 32'h110, 1, 32'h100);
        add(0, 3, 1, 0, 0, 32'h0,   1, 32'h110, 1, 32'h104);
        add(0, 3, 1, 0, 0, 32'h0,   1, 32'h114, 1, 32'h108);
        // Redirect (with stall) in the same cycle as a response and a valid head.
        add(1, 1, 1, 0, 0, 32'h0,  1, 32'h00, 0, 32'h0);
        add(0, 1, 1, 0, 0, 32'h0,  1, 32'h04, 0, 32'h0);
        add(0, 1, 1, 0, 0, 32'h0,  1, 32'h08, 1, 32'h0);
        add(0, 1, 1, 1, 1, 32'h40, 0, 32'h0C, 1, 32'h4);
        add(0, 1, 1, 0, 0, 32'h0,  1, 32'h40, 0, 32'h0);
        add(0, 1, 1, 0, 0, 32'h0,  1, 32'h44, 0, 32'h0);
        add(0, 1, 1, 0, 0, 32'h0,  1, 32'h48, 1, 32'h40);
        // Back-to-back redirects, latency 3.
        add(1, 3, 1, 0, 0, 32'h0,   1, 32'h000, 0, 32'h0);
        add(0, 3, 1, 0, 0, 32'h0,   1, 32'h004, 0, 32'h0);
        add(0, 3, 1, 0, 1, 32'h200, 0, 32'h008, 0, 32'h0);
        add(0, 3, 1, 0, 1, 32'h300, 0, 32'h200, 0, 32'h0);
        add(0, 3, 1, 0, 0, 32'h0,   1, 32'h300, 0, 32'h0);
        add(0, 3, 1, 0, 0, 32'h0,   1, 32'h304, 0, 32'h0);
        add(0, 3, 1, 0, 0, 32'h0,   1, 32'h308, 0, 32'h0);
        add(0, 3, 1, 0, 0, 32'h0,   1, 32'h30C, 0, 32'h0);
        add(0, 3, 1, 0, 0, 32'h0,   0, 32'h310, 1, 32'h300);
        // Address wrap at the top of memory.
        add(1, 1, 1, 0, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0);
        add(0, 1, 1, 0, 1, 32'hFFFF_FFFA, 0, 32'h0000_0004, 0, 32'h0);
        add(0, 1, 1, 0, 0, 32'h0,         1, 32'hFFFF_FFF8, 0, 32'h0);
        add(0, 1, 1, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0);
        add(0, 1, 1, 0, 0, 32'h0,         1, 32'h0000_0000, 1, 32'hFFFF_FFF8);
        add(0, 1, 1, 0, 0, 32'h0,         1, 32'h0000_0004, 1, 32'hFFFF_FFFC);
        add(0, 1, 1, 0, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0000_0000);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.rst) do_reset(v.lat);
            bus.mem_gnt     = v.gnt;
            bus.id_stall    = v.stall;
            bus.redirect    = v.redir;
            bus.redirect_pc = v.rpc;
            #1;
            n_vec++;
            chk(i, "mem_req", {31'd0, bus.mem_req}, {31'd0, v.req});
            chk(i, "mem_addr", bus.mem_addr, v.addr);
            if (v.valid) begin
                chk(i, "if_valid", {31'd0, bus.if_valid}, 32'd1);
                chk(i, "if_pc", bus.if_pc, v.pc);
                chk(i, "if_ir", bus.if_ir, v.pc + 32'd1);
                chk(i, "if_pc4", bus.if_pc4, v.pc + 32'd4);
            end else begin
                chk_idle(i);
            end
            tick();
        end

        // Asynchronous reset mid-stream drops everything before any clock edge.
        bus.redirect = 1'b0;
        bus.id_stall = 1'b0;
        #1;
        n_vec++;
        chk(1000, "pre-reset if_pc", bus.if_pc, 32'h4);
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        chk(1001, "async reset mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk_idle(1001);
        @(posedge clock);
        #1;
        pend_q.delete();
        bus.mem_rvalid = 1'b0;
        reset = 1'b0;
        cyc   = 0;
        #1;
        n_vec++;
        chk(1002, "post-reset mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk(1002, "post-reset mem_addr", bus.mem_addr, 32'h0);
        chk_idle(1002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
